// File: rtl/picoblaze_io_hub.sv
// PicoBlaze port-bus hub: decoded output registers, registered input mux, tick timer, prioritised IRQs.
// Define PICOBLAZE_IO_HUB_READBACK_EN to make output register i readable at 0x40+i.
module picoblaze_io_hub #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int TICK_HZ     = 1,
  parameter int NUM_OUT     = 2,
  parameter int NUM_IN      = 2,
  parameter int NUM_EXT     = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [7:0]                            port_id,
  input  logic                                  write_strobe,
  input  logic                                  read_strobe,
  input  logic [7:0]                            out_port,
  output logic [7:0]                            in_port,
  output logic                                  interrupt,
  input  logic                                  interrupt_ack,
  input  logic [8*NUM_IN-1:0]                   in_data,
  output logic [8*NUM_OUT-1:0]                  out_data,
  input  logic [(NUM_EXT > 0 ? NUM_EXT : 1)-1:0] ext_irq,
  output logic                                  tick
);

  localparam int PERIOD = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW     = $clog2(PERIOD);
  localparam int EXT_W  = (NUM_EXT > 0) ? NUM_EXT : 1;
  localparam int NSRC   = NUM_EXT + 1;
  localparam logic [7:0]    IMPL      = 8'((1 << NSRC) - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PERIOD - 1);

`ifdef PICOBLAZE_IO_HUB_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic [8*NUM_OUT-1:0] outData_q, outData_d;
  logic [7:0]           inPort_q, inPort_d;
  logic [7:0]           pend_q, pend_d;
  logic [7:0]           mask_q, mask_d;
  logic [7:0]           tickCount_q, tickCount_d;
  logic [7:0]           vec_q, vec_d;
  logic                 timerEn_q, timerEn_d;
  logic                 tick_q, tick_d;
  logic                 irq_q, irq_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [EXT_W-1:0]     sync1_q, sync2_q, sync3_q;
  logic [EXT_W-1:0]     extRise;
  logic [7:0]           pendMasked, setBits, w1cBits, ackBits;
  logic                 ackHit;
  logic [2:0]           ackIdx;
  logic                 unusedSink;

  assign unusedSink = &{1'b0, read_strobe, extRise};

  // Prescaler holds at zero while disabled, so re-enabling always starts a full period.
  always_comb begin
    tick_d      = timerEn_q && (presc_q == PRESC_MAX);
    presc_d     = (timerEn_q && !tick_d) ? presc_q + PW'(1) : '0;
    tickCount_d = tickCount_q + {7'd0, tick_d};
  end

  assign extRise = sync2_q & ~sync3_q;

  always_comb begin
    outData_d = outData_q;
    mask_d    = mask_q;
    timerEn_d = timerEn_q;
    w1cBits   = 8'h00;
    if (write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (port_id == 8'(64 + i)) outData_d[8*i +: 8] = out_port;
      end
      case (port_id)
        8'hF0:   w1cBits   = out_port & IMPL;
        8'hF1:   mask_d    = out_port & IMPL;
        8'hF2:   timerEn_d = out_port[0];
        default: ;
      endcase
    end
  end

  // Lowest index wins: scan downward so the last hit is the smallest set bit.
  always_comb begin
    pendMasked = pend_q & mask_q;
    ackHit     = 1'b0;
    ackIdx     = 3'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (pendMasked[k]) begin
        ackHit = 1'b1;
        ackIdx = 3'(k);
      end
    end
  end

  // New events are ORed in last so they survive a same-cycle W1C or acknowledge.
  always_comb begin
    setBits    = 8'h00;
    setBits[0] = tick_d;
    for (int k = 0; k < NUM_EXT; k++) begin
      setBits[k+1] = extRise[k];
    end
    ackBits = (interrupt_ack && ackHit) ? (8'h01 << ackIdx) : 8'h00;
    pend_d  = (pend_q & ~w1cBits & ~ackBits) | setBits;
    vec_d   = (interrupt_ack && ackHit) ? {5'd0, ackIdx} : vec_q;
    irq_d   = interrupt_ack ? 1'b0 : |pendMasked;
  end

  always_comb begin
    inPort_d = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (port_id == 8'(i)) inPort_d = in_data[8*i +: 8];
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      if (READBACK && port_id == 8'(64 + i)) inPort_d = outData_q[8*i +: 8];
    end
    case (port_id)
      8'hF0:   inPort_d = pend_q;
      8'hF1:   inPort_d = mask_q;
      8'hF2:   inPort_d = {7'd0, timerEn_q};
      8'hF3:   inPort_d = tickCount_q;
      8'hF4:   inPort_d = vec_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outData_q   <= '0;
      inPort_q    <= 8'h00;
      pend_q      <= 8'h00;
      mask_q      <= 8'h00;
      tickCount_q <= 8'h00;
      vec_q       <= 8'hFF;
      timerEn_q   <= 1'b1;
      tick_q      <= 1'b0;
      irq_q       <= 1'b0;
      presc_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
    end else begin
      outData_q   <= outData_d;
      inPort_q    <= inPort_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      tickCount_q <= tickCount_d;
      vec_q       <= vec_d;
      timerEn_q   <= timerEn_d;
      tick_q      <= tick_d;
      irq_q       <= irq_d;
      presc_q     <= presc_d;
      sync1_q     <= ext_irq;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
    end
  end

  assign out_data  = outData_q;
  assign in_port   = inPort_q;
  assign interrupt = irq_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Bench for picoblaze_io_hub: directed checks with literal expectations, then random traffic
// compared every cycle against a cycle-level behavioural model.
module tb_picoblaze_io_hub;

  localparam int CLK_FREQ_HZ = 100;
  localparam int TICK_HZ     = 10;
  localparam int NUM_OUT     = 2;
  localparam int NUM_IN      = 2;
  localparam int NUM_EXT     = 1;
  localparam int PERIOD      = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [7:0] IMPL = 8'h03;

`ifdef PICOBLAZE_IO_HUB_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [7:0]           port_id;
  logic                 write_strobe;
  logic                 read_strobe;
  logic [7:0]           out_port;
  logic [7:0]           in_port;
  logic                 interrupt;
  logic                 interrupt_ack;
  logic [8*NUM_IN-1:0]  in_data;
  logic [8*NUM_OUT-1:0] out_data;
  logic [0:0]           ext_irq;
  logic                 tick;

  int vectors     = 0;
  int miscompares = 0;

  picoblaze_io_hub #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ), .NUM_OUT(NUM_OUT),
    .NUM_IN(NUM_IN), .NUM_EXT(NUM_EXT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .in_data(in_data),
    .out_data(out_data), .ext_irq(ext_irq), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model state: what software would see, plus absolute edge bookkeeping for the timer.
  logic [7:0] mOut [NUM_OUT];
  logic [7:0] mPend, mMask, mCount, mVec, mInPort;
  logic       mEn, mIrq, mTick;
  logic [0:0] extHist [4];
  int         edgeCnt = 0;
  int         enStart = 0;
  int         sinceReset = 0;
  bit         modelValid = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] readModel(input logic [7:0] a);
    int ai = int'(a);
    if (ai < NUM_IN) return in_data[8*ai +: 8];
    if (ai >= 64 && ai < 64 + NUM_OUT) return READBACK ? mOut[ai-64] : 8'h00;
    case (a)
      8'hF0:   return mPend;
      8'hF1:   return mMask;
      8'hF2:   return {7'd0, mEn};
      8'hF3:   return mCount;
      8'hF4:   return mVec;
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelStep();
    logic [7:0] rd, setB, clrB, ackB, pm;
    logic       wrap, hit;
    int         idx;
    edgeCnt++;
    if (!reset_n) begin
      foreach (mOut[i]) mOut[i] = 8'h00;
      foreach (extHist[i]) extHist[i] = '0;
      mPend = 8'h00; mMask = 8'h00; mCount = 8'h00; mVec = 8'hFF; mInPort = 8'h00;
      mEn = 1'b1; mIrq = 1'b0; mTick = 1'b0;
      enStart = edgeCnt;
      sinceReset = 0;
      modelValid = 1'b1;
      return;
    end
    sinceReset++;
    rd = readModel(port_id);
    for (int i = 3; i > 0; i--) extHist[i] = extHist[i-1];
    extHist[0] = ext_irq;
    wrap = mEn && ((edgeCnt - enStart) % PERIOD == 0);
    setB = 8'h00;
    setB[0] = wrap;
    for (int k = 0; k < NUM_EXT; k++) setB[k+1] = extHist[2][k] & ~extHist[3][k];
    pm = mPend & mMask;
    hit = 1'b0;
    idx = 0;
    for (int k = 7; k >= 0; k--) if (pm[k]) begin hit = 1'b1; idx = k; end
    ackB = (interrupt_ack && hit) ? 8'(1 << idx) : 8'h00;
    clrB = (write_strobe && port_id == 8'hF0) ? (out_port & IMPL) : 8'h00;
    mIrq = interrupt_ack ? 1'b0 : (pm != 8'h00);
    mPend = (mPend & ~clrB & ~ackB) | setB;
    if (interrupt_ack && hit) mVec = 8'(idx);
    mTick = wrap;
    mCount = mCount + 8'(wrap);
    mInPort = rd;
    if (write_strobe) begin
      if (int'(port_id) >= 64 && int'(port_id) < 64 + NUM_OUT) mOut[int'(port_id) - 64] = out_port;
      if (port_id == 8'hF1) mMask = out_port & IMPL;
      if (port_id == 8'hF2) begin
        if (out_port[0] && !mEn) enStart = edgeCnt;
        mEn = out_port[0];
      end
    end
  endtask

  task automatic checkOutput();
    logic [8*NUM_OUT-1:0] expOut;
    for (int i = 0; i < NUM_OUT; i++) expOut[8*i +: 8] = mOut[i];
    check("model_out_data", 32'(out_data), 32'(expOut));
    check("model_in_port", 32'(in_port), 32'(mInPort));
    check("model_interrupt", 32'(interrupt), 32'(mIrq));
    check("model_tick", 32'(tick), 32'(mTick));
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (modelValid) checkOutput();
  end

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic waitUntil(input int k);
    int guard = 0;
    while (sinceReset < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (sinceReset != k) begin
      miscompares++;
      $display("[TB] FAIL wait_sync: got cycle %0d, expected %0d", sinceReset, k);
    end
  endtask

  task automatic applyStimulus();
    reset_n = ($urandom_range(0, 399) != 0);
    case ($urandom_range(0, 9))
      0:       port_id = 8'($urandom_range(0, 2));
      1:       port_id = 8'(64 + $urandom_range(0, 2));
      2, 3, 4, 5, 6: port_id = 8'(240 + $urandom_range(0, 5));
      default: port_id = 8'($urandom);
    endcase
    out_port = 8'($urandom);
    if (port_id == 8'hF2) out_port[0] = ($urandom_range(0, 7) != 0);
    write_strobe  = ($urandom_range(0, 3) == 0);
    read_strobe   = 1'($urandom);
    interrupt_ack = ($urandom_range(0, 5) == 0);
    in_data       = 16'($urandom);
    if ($urandom_range(0, 4) == 0) ext_irq = ~ext_irq;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    reset_n = 1'b0; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = 8'h00; interrupt_ack = 1'b0; in_data = '0; ext_irq = 1'b0;

    // Reset values and basic port I/O
    doReset();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_interrupt", 32'(interrupt), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    port_id = 8'h41; out_port = 8'hA5; write_strobe = 1'b1;
    waitUntil(1);
    write_strobe = 1'b0;
    check("wr_out1", 32'(out_data[15:8]), 32'hA5);
    in_data[7:0] = 8'h3C; port_id = 8'h00;
    waitUntil(2);
    check("rd_in0", 32'(in_port), 32'h3C);
    port_id = 8'h7E;
    waitUntil(3);
    check("rd_unmapped", 32'(in_port), 32'h00);
    port_id = 8'hF4;
    waitUntil(4);
    check("rst_vec", 32'(in_port), 32'hFF);
    port_id = 8'hF2;
    waitUntil(5);
    check("rst_timer_ctrl", 32'(in_port), 32'h01);

    // Timer ticks every PERIOD cycles and raises the masked interrupt
    doReset();
    port_id = 8'hF1; out_port = 8'h01; write_strobe = 1'b1;
    waitUntil(1);
    write_strobe = 1'b0;
    waitUntil(9);
    check("tick_before_first", 32'(tick), 32'h0);
    waitUntil(10);
    check("tick_first", 32'(tick), 32'h1);
    check("irq_at_tick", 32'(interrupt), 32'h0);
    waitUntil(11);
    check("irq_after_tick", 32'(interrupt), 32'h1);
    check("tick_one_cycle", 32'(tick), 32'h0);
    waitUntil(20);
    check("tick_second", 32'(tick), 32'h1);
    port_id = 8'hF3;
    waitUntil(31);
    check("tick_count_3", 32'(in_port), 32'h03);

    // Acknowledge: timer bit first, then the external line
    port_id = 8'hF2; out_port = 8'h00; write_strobe = 1'b1;
    waitUntil(32);
    port_id = 8'hF1; out_port = 8'h03;
    waitUntil(33);
    write_strobe = 1'b0;
    ext_irq = 1'b1;
    waitUntil(38);
    check("irq_both_pending", 32'(interrupt), 32'h1);
    port_id = 8'hF0;
    waitUntil(39);
    check("pend_both", 32'(in_port), 32'h03);
    interrupt_ack = 1'b1; port_id = 8'hF4;
    waitUntil(40);
    interrupt_ack = 1'b0;
    check("irq_forced_low", 32'(interrupt), 32'h0);
    waitUntil(41);
    check("vec_first", 32'(in_port), 32'h00);
    check("irq_reassert", 32'(interrupt), 32'h1);
    port_id = 8'hF0;
    waitUntil(42);
    check("pend_after_ack", 32'(in_port), 32'h02);
    interrupt_ack = 1'b1; port_id = 8'hF4;
    waitUntil(43);
    interrupt_ack = 1'b0;
    check("irq_low_second", 32'(interrupt), 32'h0);
    waitUntil(44);
    check("vec_second", 32'(in_port), 32'h01);
    check("irq_stays_low", 32'(interrupt), 32'h0);

    // Re-enable, then W1C of bit0 lands on the tick edge
    port_id = 8'hF2; out_port = 8'h01; write_strobe = 1'b1;
    waitUntil(45);
    write_strobe = 1'b0;
    waitUntil(54);
    check("tick_reen_before", 32'(tick), 32'h0);
    port_id = 8'hF0; out_port = 8'h01; write_strobe = 1'b1;
    waitUntil(55);
    write_strobe = 1'b0;
    check("tick_reen", 32'(tick), 32'h1);
    waitUntil(56);
    check("pend_set_wins", 32'(in_port), 32'h01);
    check("irq_set_wins", 32'(interrupt), 32'h1);

    // Disabled timer: no ticks, frozen count, then exact restart
    port_id = 8'hF2; out_port = 8'h00; write_strobe = 1'b1;
    waitUntil(57);
    write_strobe = 1'b0; port_id = 8'hF3;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick) seen++;
    end
    check("no_ticks_disabled", 32'(seen), 32'h0);
    check("count_frozen", 32'(in_port), 32'h04);
    port_id = 8'hF2; out_port = 8'h01; write_strobe = 1'b1;
    waitUntil(108);
    write_strobe = 1'b0;
    waitUntil(117);
    check("tick_restart_before", 32'(tick), 32'h0);
    waitUntil(118);
    check("tick_restart", 32'(tick), 32'h1);

    // Output register readback
    port_id = 8'h40; out_port = 8'h5A; write_strobe = 1'b1;
    waitUntil(119);
    write_strobe = 1'b0;
    check("wr_out0", 32'(out_data[7:0]), 32'h5A);
    waitUntil(120);
    check("readback_out0", 32'(in_port), READBACK ? 32'h5A : 32'h00);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      applyStimulus();
    end
    @(negedge clk);
    reset_n = 1'b1; write_strobe = 1'b0; interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
